// File: rtl/iguana_reg_resp.sv
// Register-bus responder: small 32-bit register bank behind a programmable-latency handshake.
// Optional sticky write-lock on register 1 bit 0 is enabled by defining IGUANA_REG_RESP_LOCK_EN.
module iguana_reg_resp #(
  parameter int unsigned          AddrWidth  = 48,
  parameter logic [AddrWidth-1:0] BaseAddr   = AddrWidth'(48'h0000_2000_2000),
  parameter int unsigned          NumRegs    = 8,
  parameter int unsigned          WaitCycles = 2,
  parameter logic [31:0]          IdValue    = 32'h1C0A_0001
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    reg_valid_i,
  input  logic                    reg_write_i,
  input  logic [AddrWidth-1:0]    reg_addr_i,
  input  logic [31:0]             reg_wdata_i,
  input  logic [3:0]              reg_wstrb_i,
  output logic                    reg_ready_o,
  output logic [31:0]             reg_rdata_o,
  output logic                    reg_error_o,
  output logic [32*NumRegs-1:0]   regs_o
);

  localparam int unsigned CntW       = 4;
  localparam int unsigned RegionSize = 4096;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [CntW-1:0]       cnt_q;
  logic                  write_q;
  logic [AddrWidth-1:0]  addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           regs_q [1:NumRegs-1];

  logic                  dec_write;
  logic [AddrWidth-1:0]  dec_addr;
  logic [AddrWidth-1:0]  offset;
  logic [9:0]            index;
  logic                  lock_err;
  logic                  dec_error;
  logic [31:0]           rd_val;
  logic                  commit;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (reg_valid_i) state_d = (WaitCycles == 0) ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (!reg_valid_i)                         state_d = S_IDLE;
        else if (cnt_q == CntW'(WaitCycles - 1))  state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Decode live inputs in IDLE (zero-wait path), otherwise the latched request
  always_comb begin
    dec_write = (state_q == S_IDLE) ? reg_write_i : write_q;
    dec_addr  = (state_q == S_IDLE) ? reg_addr_i  : addr_q;
    offset    = dec_addr - BaseAddr;
    index     = offset[11:2];
`ifdef IGUANA_REG_RESP_LOCK_EN
    lock_err  = dec_write && regs_q[1][0];
`else
    lock_err  = 1'b0;
`endif
    dec_error = (dec_addr < BaseAddr) || (offset >= AddrWidth'(RegionSize)) ||
                (dec_addr[1:0] != 2'b00) || (index >= 10'(NumRegs)) ||
                (dec_write && (index == 10'd0)) || lock_err;
  end

  always_comb begin
    regs_o        = '0;
    regs_o[31:0]  = IdValue;
    for (int i = 1; i < NumRegs; i++) regs_o[32*i +: 32] = regs_q[i];
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (index == 10'(i)) rd_val = regs_o[32*i +: 32];
    end
  end

  // Error flag registered on RESP entry gates the write commit
  assign commit = (state_q == S_RESP) && write_q && !reg_error_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      reg_ready_o <= 1'b0;
      reg_rdata_o <= '0;
      reg_error_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= (state_q == S_WAIT && state_d == S_WAIT) ? cnt_q + CntW'(1) : '0;
      if (state_q == S_IDLE && reg_valid_i) begin
        write_q <= reg_write_i;
        addr_q  <= reg_addr_i;
        wdata_q <= reg_wdata_i;
        wstrb_q <= reg_wstrb_i;
      end
      reg_ready_o <= (state_d == S_RESP);
      reg_error_o <= (state_d == S_RESP) && dec_error;
      reg_rdata_o <= ((state_d == S_RESP) && !dec_error && !dec_write) ? rd_val : '0;
    end
  end

  // Register bank, byte-lane writes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 1; i < NumRegs; i++) regs_q[i] <= '0;
    end else if (commit) begin
      for (int i = 1; i < NumRegs; i++) begin
        for (int b = 0; b < 4; b++) begin
          if ((index == 10'(i)) && wstrb_q[b]) regs_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_iguana_reg_resp.sv
// Directed self-checking bench for iguana_reg_resp (default parameters, optional lock via macro).
module tb_iguana_reg_resp;

  localparam int unsigned WaitC = 2;
  localparam int unsigned Lat   = 1 + WaitC;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid, write;
  logic [47:0]  addr;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         ready;
  logic [31:0]  rdata;
  logic         error;
  logic [255:0] regs;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rd;
  logic        er;
  int          pulses;

  iguana_reg_resp #(
    .AddrWidth(48), .BaseAddr(48'h0000_2000_2000), .NumRegs(8),
    .WaitCycles(WaitC), .IdValue(32'h1C0A_0001)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .reg_valid_i(valid), .reg_write_i(write), .reg_addr_i(addr),
    .reg_wdata_i(wdata), .reg_wstrb_i(wstrb),
    .reg_ready_o(ready), .reg_rdata_o(rdata), .reg_error_o(error),
    .regs_o(regs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction; request fields are scrambled after acceptance to prove they are latched
  task automatic req(input string tag, input logic w, input logic [47:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r, output logic e);
    int  n = 0;
    bit  seen = 0;
    valid = 1'b1; write = w; addr = a; wdata = d; wstrb = s;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin addr = a ^ 48'h4; wdata = ~d; wstrb = ~s; end
      if (ready) seen = 1;
    end
    check({tag, "_latency"}, 256'(n), 256'(Lat));
    r = rdata; e = error;
    valid = 1'b0; write = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    @(posedge clk); #1;
    check({tag, "_one_pulse"}, 256'(ready), 256'(0));
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; write = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 256'(ready), 256'(0));
    check("rst_rdata", 256'(rdata), 256'(0));
    check("rst_error", 256'(error), 256'(0));
    check("rst_regs",  regs, 256'h1C0A_0001);
    rst = 1'b0;
    @(posedge clk); #1;

    req("rd_id", 1'b0, 48'h0000_2000_2000, 32'h0, 4'h0, rd, er);
    check("rd_id_data", 256'(rd), 256'(32'h1C0A_0001));
    check("rd_id_err",  256'(er), 256'(0));

    req("wr_r2", 1'b1, 48'h0000_2000_2008, 32'hDEAD_BEEF, 4'b0101, rd, er);
    check("wr_r2_err",  256'(er), 256'(0));
    check("wr_r2_regs", 256'(regs[95:64]), 256'(32'h00AD_00EF));
    req("rd_r2", 1'b0, 48'h0000_2000_2008, 32'h0, 4'h0, rd, er);
    check("rd_r2_data", 256'(rd), 256'(32'h00AD_00EF));
    check("rd_r2_err",  256'(er), 256'(0));

    req("wr_r7", 1'b1, 48'h0000_2000_201C, 32'hA5A5_5A5A, 4'hF, rd, er);
    check("wr_r7_err", 256'(er), 256'(0));
    req("rd_r7", 1'b0, 48'h0000_2000_201C, 32'h0, 4'h0, rd, er);
    check("rd_r7_data", 256'(rd), 256'(32'hA5A5_5A5A));

    req("rd_idx8", 1'b0, 48'h0000_2000_2020, 32'h0, 4'h0, rd, er);
    check("rd_idx8_err",  256'(er), 256'(1));
    check("rd_idx8_data", 256'(rd), 256'(0));
    req("wr_r0", 1'b1, 48'h0000_2000_2000, 32'hFFFF_FFFF, 4'hF, rd, er);
    check("wr_r0_err", 256'(er), 256'(1));
    req("rd_unal", 1'b0, 48'h0000_2000_2006, 32'h0, 4'h0, rd, er);
    check("rd_unal_err",  256'(er), 256'(1));
    check("rd_unal_data", 256'(rd), 256'(0));
    req("rd_above", 1'b0, 48'h0000_2000_3000, 32'h0, 4'h0, rd, er);
    check("rd_above_err",  256'(er), 256'(1));
    check("rd_above_data", 256'(rd), 256'(0));
    req("rd_below", 1'b0, 48'h0000_2000_1FFC, 32'h0, 4'h0, rd, er);
    check("rd_below_err", 256'(er), 256'(1));
    check("illegal_regs", regs,
          {32'hA5A5_5A5A, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00AD_00EF, 32'h0, 32'h1C0A_0001});

    req("wr_nostrb", 1'b1, 48'h0000_2000_2014, 32'hCAFE_F00D, 4'h0, rd, er);
    check("wr_nostrb_err",  256'(er), 256'(0));
    check("wr_nostrb_regs", 256'(regs[191:160]), 256'(0));

    // Valid dropped one cycle into WAIT: aborted, no pulse, no write
    valid = 1'b1; write = 1'b1; addr = 48'h0000_2000_200C; wdata = 32'h1234_5678; wstrb = 4'hF;
    @(posedge clk); #1;
    valid = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    write = 1'b0;
    check("drop_pulses", 256'(pulses), 256'(0));
    check("drop_r3",     256'(regs[127:96]), 256'(0));
    req("after_drop", 1'b0, 48'h0000_2000_2008, 32'h0, 4'h0, rd, er);
    check("after_drop_data", 256'(rd), 256'(32'h00AD_00EF));

    // Reset asserted during WAIT of a write
    valid = 1'b1; write = 1'b1; addr = 48'h0000_2000_2008; wdata = 32'h1111_1111; wstrb = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_ready", 256'(ready), 256'(0));
    check("midrst_rdata", 256'(rdata), 256'(0));
    check("midrst_error", 256'(error), 256'(0));
    check("midrst_regs",  regs, 256'h1C0A_0001);
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0; write = 1'b0;
    @(posedge clk); #1;
    req("after_rst", 1'b0, 48'h0000_2000_2008, 32'h0, 4'h0, rd, er);
    check("after_rst_data", 256'(rd), 256'(0));
    check("after_rst_err",  256'(er), 256'(0));

    req("wr_r1", 1'b1, 48'h0000_2000_2004, 32'h0000_0001, 4'hF, rd, er);
    check("wr_r1_err",  256'(er), 256'(0));
    check("wr_r1_regs", 256'(regs[63:32]), 256'(1));
    req("wr_r4", 1'b1, 48'h0000_2000_2010, 32'h0000_0055, 4'hF, rd, er);
`ifdef IGUANA_REG_RESP_LOCK_EN
    check("wr_r4_err",  256'(er), 256'(1));
    check("wr_r4_regs", 256'(regs[159:128]), 256'(0));
`else
    check("wr_r4_err",  256'(er), 256'(0));
    check("wr_r4_regs", 256'(regs[159:128]), 256'(32'h55));
`endif
    req("rd_r1", 1'b0, 48'h0000_2000_2004, 32'h0, 4'h0, rd, er);
    check("rd_r1_data", 256'(rd), 256'(1));
    check("rd_r1_err",  256'(er), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
